// File: rtl/insn_queue.sv
// insn_queue: fetch-to-decode {pc, insn} FIFO with a valid/ready handshake on both sides.
// Optional same-cycle enq->deq bypass when empty: define INSN_QUEUE_BYPASS_EN.
module insn_queue #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     enq_valid_i,
  input  logic [AWIDTH-1:0]        enq_pc_i,
  input  logic [DWIDTH-1:0]        enq_insn_i,
  output logic                     enq_ready_o,
  output logic                     deq_valid_o,
  output logic [AWIDTH-1:0]        deq_pc_o,
  output logic [DWIDTH-1:0]        deq_insn_o,
  input  logic                     deq_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("insn_queue: DEPTH must be a power of 2 and >= 2");
  end

  logic [AWIDTH-1:0] pc_mem   [DEPTH];
  logic [DWIDTH-1:0] insn_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[PW-2:0] == wr_ptr[PW-2:0]) &&
                 (rd_ptr[PW-1] != wr_ptr[PW-1]);

  assign enq_ready_o = ~full;
  assign count_o     = wr_ptr - rd_ptr;

  // Pops only ever drain stored entries; a bypassed entry never touches the pointers.
  assign pop = ~empty & deq_ready_i & ~flush_i;

`ifdef INSN_QUEUE_BYPASS_EN
  logic byp;

  assign byp  = empty & enq_valid_i & ~flush_i;
  assign push = enq_valid_i & ~full & ~flush_i & ~(byp & deq_ready_i);

  always_comb begin
    deq_valid_o = 1'b0;
    deq_pc_o    = '0;
    deq_insn_o  = '0;
    if (!empty) begin
      deq_valid_o = 1'b1;
      deq_pc_o    = pc_mem[rd_ptr[PW-2:0]];
      deq_insn_o  = insn_mem[rd_ptr[PW-2:0]];
    end else if (byp) begin
      deq_valid_o = 1'b1;
      deq_pc_o    = enq_pc_i;
      deq_insn_o  = enq_insn_i;
    end
  end
`else
  assign push = enq_valid_i & ~full & ~flush_i;

  always_comb begin
    deq_valid_o = 1'b0;
    deq_pc_o    = '0;
    deq_insn_o  = '0;
    if (!empty) begin
      deq_valid_o = 1'b1;
      deq_pc_o    = pc_mem[rd_ptr[PW-2:0]];
      deq_insn_o  = insn_mem[rd_ptr[PW-2:0]];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr[PW-2:0]]   <= enq_pc_i;
      insn_mem[wr_ptr[PW-2:0]] <= enq_insn_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_i) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_insn_queue.sv
// tb_insn_queue: directed vector table plus hand sequences for insn_queue.
// Expectations assume DEPTH=4; the bypass sequence runs when INSN_QUEUE_BYPASS_EN is defined.
module tb_insn_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        enq_valid_i;
  logic [31:0] enq_pc_i;
  logic [31:0] enq_insn_i;
  logic        enq_ready_o;
  logic        deq_valid_o;
  logic [31:0] deq_pc_o;
  logic [31:0] deq_insn_o;
  logic        deq_ready_i;
  logic [2:0]  count_o;

  insn_queue #(.AWIDTH(32), .DWIDTH(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .enq_pc_i    (enq_pc_i),
    .enq_insn_i  (enq_insn_i),
    .enq_ready_o (enq_ready_o),
    .deq_valid_o (deq_valid_o),
    .deq_pc_o    (deq_pc_o),
    .deq_insn_o  (deq_insn_o),
    .deq_ready_i (deq_ready_i),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        ev;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        dr;
    logic [2:0]  cnt;
    logic        dv;
    logic        er;
    logic [31:0] epc;
    logic [31:0] eins;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int bad   = 0;

  localparam logic [31:0] BASE = 32'h0100_0000;
  logic [31:0] pcs [5];
  logic [31:0] ins [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] cnt,
                         input logic dv, input logic er,
                         input logic [31:0] pc, input logic [31:0] in);
    chk({tag, ".count"}, 32'(count_o), 32'(cnt));
    chk({tag, ".deq_valid"}, 32'(deq_valid_o), 32'(dv));
    chk({tag, ".enq_ready"}, 32'(enq_ready_o), 32'(er));
    chk({tag, ".deq_pc"}, deq_pc_o, pc);
    chk({tag, ".deq_insn"}, deq_insn_o, in);
  endtask

  task automatic drive(input logic fl, input logic ev,
                       input logic [31:0] pc, input logic [31:0] in,
                       input logic dr);
    flush_i     = fl;
    enq_valid_i = ev;
    enq_pc_i    = pc;
    enq_insn_i  = in;
    deq_ready_i = dr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // e: entry index to enqueue (-1 none); h: expected head index (-1 empty)
  task automatic add(input logic fl, input int e, input logic dr,
                     input logic [2:0] cnt, input logic er, input int h);
    vec_t v;
    v.fl   = fl;
    v.ev   = (e >= 0);
    v.pc   = (e >= 0) ? pcs[e] : 32'h0;
    v.ins  = (e >= 0) ? ins[e] : 32'h0;
    v.dr   = dr;
    v.cnt  = cnt;
    v.dv   = (h >= 0);
    v.er   = er;
    v.epc  = (h >= 0) ? pcs[h] : 32'h0;
    v.eins = (h >= 0) ? ins[h] : 32'h0;
    tv.push_back(v);
  endtask

  initial begin
    pcs[0] = BASE;         ins[0] = 32'h0000_0013;
    pcs[1] = BASE + 32'h4; ins[1] = 32'h0010_0093;
    pcs[2] = BASE + 32'h8; ins[2] = 32'h0020_0113;
    pcs[3] = BASE + 32'hC; ins[3] = 32'h0030_0193;
    pcs[4] = BASE + 32'h10; ins[4] = 32'h0040_0213;

    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #12;
    chk_out("reset", 3'd0, 1'b0, 1'b1, 32'h0, 32'h0);
    rst = 1'b1;
    next_cycle();

`ifndef INSN_QUEUE_BYPASS_EN
    // in-order, one-cycle latency
    add(0, 0, 1, 0, 1, -1);
    add(0, 1, 1, 1, 1, 0);
    add(0, 2, 1, 1, 1, 1);
    add(0, -1, 1, 1, 1, 2);
    add(0, -1, 1, 0, 1, -1);
    // fill to full, 5th held, one pop frees a slot next cycle
    add(0, 0, 0, 0, 1, -1);
    add(0, 1, 0, 1, 1, 0);
    add(0, 2, 0, 2, 1, 0);
    add(0, 3, 0, 3, 1, 0);
    add(0, 4, 0, 4, 0, 0);
    add(0, 4, 1, 4, 0, 0);
    add(0, 4, 0, 3, 1, 1);
    add(0, -1, 0, 4, 0, 1);
    add(0, -1, 1, 4, 0, 1);
    add(0, -1, 1, 3, 1, 2);
    add(0, -1, 1, 2, 1, 3);
    add(0, -1, 1, 1, 1, 4);
    add(0, -1, 1, 0, 1, -1);
    // flush with concurrent push and pop
    add(0, 0, 0, 0, 1, -1);
    add(0, 1, 0, 1, 1, 0);
    add(0, 2, 0, 2, 1, 0);
    add(1, 3, 1, 3, 1, 0);
    add(0, -1, 0, 0, 1, -1);
    add(0, 4, 0, 0, 1, -1);
    add(0, -1, 0, 1, 1, 4);
    add(0, -1, 1, 1, 1, 4);
    add(0, -1, 0, 0, 1, -1);

    foreach (tv[i]) begin
      drive(tv[i].fl, tv[i].ev, tv[i].pc, tv[i].ins, tv[i].dr);
      #1;
      chk_out($sformatf("vec%0d", i), tv[i].cnt, tv[i].dv, tv[i].er,
              tv[i].epc, tv[i].eins);
      next_cycle();
    end

    // wrap: 10 push/pop pairs at full throughput
    for (int k = 0; k <= 10; k++) begin
      if (k < 10)
        drive(1'b0, 1'b1, BASE + 32'(4 * k), 32'h13 | 32'(k << 7), 1'b1);
      else
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      #1;
      if (k == 0)
        chk_out("wrap0", 3'd0, 1'b0, 1'b1, 32'h0, 32'h0);
      else
        chk_out($sformatf("wrap%0d", k), 3'd1, 1'b1, 1'b1,
                BASE + 32'(4 * (k - 1)), 32'h13 | 32'((k - 1) << 7));
      next_cycle();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk_out("wrap_end", 3'd0, 1'b0, 1'b1, 32'h0, 32'h0);
    next_cycle();
`else
    // bypass: empty queue, push with decode ready
    drive(1'b0, 1'b1, pcs[4], ins[4], 1'b1);
    #1;
    chk_out("byp", 3'd0, 1'b1, 1'b1, pcs[4], ins[4]);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk_out("byp_after", 3'd0, 1'b0, 1'b1, 32'h0, 32'h0);
    next_cycle();
`endif

    // async reset mid-run with 3 entries held
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, pcs[k], ins[k], 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk_out("pre_rst", 3'd3, 1'b1, 1'b1, pcs[0], ins[0]);
    #1;
    rst = 1'b0;
    #1;
    chk_out("mid_rst", 3'd0, 1'b0, 1'b1, 32'h0, 32'h0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    chk_out("post_rst", 3'd0, 1'b0, 1'b1, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
